// File: rtl/data_memory_pipelined.sv
// Synchronous single-port data memory with a valid/ready request port,
// a READ_LATENCY-deep read pipeline, an optional post-reset zero-fill
// engine, out-of-range address flagging and a tri-state read bus.
module data_memory_pipelined #(
    parameter int D_ADDR_W       = 12,
    parameter int DATA_W         = 8,
    parameter int D_MEMORY_DEPTH = 1 << D_ADDR_W,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [D_ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                output_enable,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_valid,
    output logic                busy,
    output logic                addr_error,
    output logic                dbg_state
);

    // Handshake: a request is accepted at a rising edge exactly when
    // req_valid and req_ready are both high at that edge. req_ready is a
    // function of registered state and rst only, never of req_valid, and a
    // requester must hold its request fields stable until accepted.

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    localparam logic [D_ADDR_W-1:0] LAST_ADDR = D_ADDR_W'(D_MEMORY_DEPTH - 1);

    state_t                state;
    state_t                next_state;
    logic                  settle;
    logic                  active;
    logic [D_ADDR_W-1:0]   clr_cnt;
    logic                  in_range;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [DATA_W-1:0]     mem_rd;
    logic [DATA_W-1:0]     last_data;
    logic                  last_vld;
    logic [DATA_W-1:0]     rd_reg;
    logic                  read_valid_r;
    logic                  addr_error_r;
    logic [DATA_W-1:0]     mem [D_MEMORY_DEPTH];

    // Outputs stay quiet while rst is high and for the one cycle after it.
    assign active     = !rst && !settle;
    assign req_ready  = (state == IDLE) && active;
    assign busy       = (state == CLEAR) && active;
    assign in_range   = ({1'b0, data_addr} < (D_ADDR_W + 1)'(D_MEMORY_DEPTH));
    assign rd_accept  = req_ready && req_valid && !req_write;
    assign wr_accept  = req_ready && req_valid && req_write && in_range;
    assign mem_rd     = in_range ? mem[data_addr] : '0;
    assign read_valid = read_valid_r && active;
    assign addr_error = addr_error_r && active;
    assign read_data  = (output_enable && (state == IDLE) && active) ? rd_reg : 'z;
    assign dbg_state  = state;

    // Remember that the previous edge was a reset edge.
    always_ff @(posedge clk) begin
        settle <= rst;
    end

    // State register; reset picks the fill engine or goes straight to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? CLEAR : IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Leave CLEAR once the last word has been zeroed.
    always_comb begin
        next_state = state;
        if ((state == CLEAR) && active && (clr_cnt == LAST_ADDR)) begin
            next_state = IDLE;
        end
    end

    // Fill address counter, restarts from 0 on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (busy) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Memory array: fill engine has the port while busy, otherwise writes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_accept) begin
            mem[data_addr] <= write_data;
        end
    end

    // Read pipeline: READ_LATENCY-1 stages ahead of the output register.
    generate
        if (READ_LATENCY > 1) begin : g_pipe
            localparam int PD = READ_LATENCY - 1;
            logic [DATA_W-1:0] pd [PD];
            logic [PD-1:0]     pv;

            // Shift read data and its valid bit towards the output register.
            always_ff @(posedge clk) begin
                pd[0] <= mem_rd;
                for (int i = 1; i < PD; i++) begin
                    pd[i] <= pd[i-1];
                end
                if (rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= rd_accept;
                    for (int i = 1; i < PD; i++) begin
                        pv[i] <= pv[i-1];
                    end
                end
            end

            assign last_data = pd[PD-1];
            assign last_vld  = pv[PD-1];
        end else begin : g_direct
            assign last_data = mem_rd;
            assign last_vld  = rd_accept;
        end
    endgenerate

    // Output register: holds the last completed read between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_valid_r <= 1'b0;
            addr_error_r <= 1'b0;
            rd_reg       <= '0;
        end else begin
            read_valid_r <= last_vld;
            addr_error_r <= req_ready && req_valid && !in_range;
            if (last_vld) begin
                rd_reg <= last_data;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Testbench for data_memory_pipelined. Six instances share one request
// stream: latencies 1..4 at depth 16, a depth-12 instance for address
// range errors, and a second latency-1 instance whose bus is pulled the
// opposite way so an undriven bus can be told apart from a driven value.
module tb_data_memory_pipelined;

    localparam int N = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_write;
    logic [3:0] data_addr;
    logic [7:0] write_data;
    logic       output_enable;
    logic       oor_en;
    logic       req_valid_oor;

    logic       rdy  [N];
    logic       rvld [N];
    logic       bsy  [N];
    logic       aerr [N];
    logic       dst  [N];
    logic [7:0] rdv  [N];

    wire [7:0] rd_up;
    wire [7:0] rd_l2;
    wire [7:0] rd_l3;
    wire [7:0] rd_l4;
    wire [7:0] rd_oor;
    wire [7:0] rd_dn;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q [N][$];
    int         due_q [N][$];
    logic [7:0] m16 [16];
    logic [7:0] m12 [16];

    for (genvar b = 0; b < 8; b++) begin : g_pull
        pullup   (rd_up[b]);
        pulldown (rd_dn[b]);
    end

    assign req_valid_oor = req_valid && oor_en;
    assign rdv[0] = rd_up;
    assign rdv[1] = rd_l2;
    assign rdv[2] = rd_l3;
    assign rdv[3] = rd_l4;
    assign rdv[4] = rd_oor;
    assign rdv[5] = rd_dn;

    data_memory_pipelined #(.D_ADDR_W(4), .DATA_W(8), .D_MEMORY_DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_write(req_write),
        .data_addr(data_addr), .write_data(write_data), .output_enable(output_enable), .read_data(rd_up),
        .read_valid(rvld[0]), .busy(bsy[0]), .addr_error(aerr[0]), .dbg_state(dst[0]));
    data_memory_pipelined #(.D_ADDR_W(4), .DATA_W(8), .D_MEMORY_DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_write(req_write),
        .data_addr(data_addr), .write_data(write_data), .output_enable(output_enable), .read_data(rd_l2),
        .read_valid(rvld[1]), .busy(bsy[1]), .addr_error(aerr[1]), .dbg_state(dst[1]));
    data_memory_pipelined #(.D_ADDR_W(4), .DATA_W(8), .D_MEMORY_DEPTH(16), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_write(req_write),
        .data_addr(data_addr), .write_data(write_data), .output_enable(output_enable), .read_data(rd_l3),
        .read_valid(rvld[2]), .busy(bsy[2]), .addr_error(aerr[2]), .dbg_state(dst[2]));
    data_memory_pipelined #(.D_ADDR_W(4), .DATA_W(8), .D_MEMORY_DEPTH(16), .READ_LATENCY(4), .CLEAR_ON_RESET(1'b1)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[3]), .req_write(req_write),
        .data_addr(data_addr), .write_data(write_data), .output_enable(output_enable), .read_data(rd_l4),
        .read_valid(rvld[3]), .busy(bsy[3]), .addr_error(aerr[3]), .dbg_state(dst[3]));
    data_memory_pipelined #(.D_ADDR_W(4), .DATA_W(8), .D_MEMORY_DEPTH(12), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_oor (
        .clk(clk), .rst(rst), .req_valid(req_valid_oor), .req_ready(rdy[4]), .req_write(req_write),
        .data_addr(data_addr), .write_data(write_data), .output_enable(output_enable), .read_data(rd_oor),
        .read_valid(rvld[4]), .busy(bsy[4]), .addr_error(aerr[4]), .dbg_state(dst[4]));
    data_memory_pipelined #(.D_ADDR_W(4), .DATA_W(8), .D_MEMORY_DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_dn (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[5]), .req_write(req_write),
        .data_addr(data_addr), .write_data(write_data), .output_enable(output_enable), .read_data(rd_dn),
        .read_valid(rvld[5]), .busy(bsy[5]), .addr_error(aerr[5]), .dbg_state(dst[5]));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic int lat_of(input int i);
        case (i)
            1:       return 2;
            2:       return 3;
            3:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_models();
        for (int a = 0; a < 16; a++) begin
            m16[a] = 8'h00;
            m12[a] = 8'h00;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        data_addr  = a;
        write_data = d;
        m16[a] = d;
        if (oor_en && a < 12) m12[a] = d;
        tick();
        check("aerr_l1_wr", aerr[0], 1'b0);
        if (oor_en) check($sformatf("aerr_oor_wr_%0d", a), aerr[4], (a >= 12));
    endtask

    task automatic do_read(input logic [3:0] a);
        req_valid = 1'b1;
        req_write = 1'b0;
        data_addr = a;
        for (int i = 0; i < N; i++) begin
            if (i == 4 && !oor_en) continue;
            exp_q[i].push_back((i == 4) ? ((a < 12) ? m12[a] : 8'h00) : m16[a]);
            due_q[i].push_back(cyc + lat_of(i));
        end
        tick();
        check("aerr_l1_rd", aerr[0], 1'b0);
        if (oor_en) check($sformatf("aerr_oor_rd_%0d", a), aerr[4], (a >= 12));
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Release reset and count busy cycles of the depth-16 and depth-12 parts.
    task automatic time_clear(input string tag);
        int n16 = 0;
        int n12 = 0;
        int viol = 0;
        bit seen = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bsy[4]) n12++;
            if (bsy[0]) begin
                seen = 1'b1;
                n16++;
                if (rdy[0] || rdy[3]) viol++;
            end else if (seen) begin
                break;
            end
        end
        req_valid = 1'b0;
        check({tag, "_busy16"}, n16, 16);
        check({tag, "_busy12"}, n12, 12);
        check({tag, "_ready_low"}, viol, 0);
        check({tag, "_ready_after"}, rdy[0], 1'b1);
        check({tag, "_ready_after_l4"}, rdy[3], 1'b1);
        zero_models();
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rvld[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("unexpected_rvalid_u%0d", i), rvld[i], 1'b0);
                end else begin
                    check($sformatf("rvalid_cycle_u%0d", i), cyc, due_q[i][0]);
                    check($sformatf("rdata_u%0d", i), rdv[i], exp_q[i][0]);
                    void'(exp_q[i].pop_front());
                    void'(due_q[i].pop_front());
                end
            end else if (exp_q[i].size() != 0 && due_q[i][0] <= cyc) begin
                check($sformatf("rvalid_missing_u%0d", i), rvld[i], 1'b1);
                void'(exp_q[i].pop_front());
                void'(due_q[i].pop_front());
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        data_addr     = 4'd0;
        write_data    = 8'h00;
        output_enable = 1'b1;
        oor_en        = 1'b0;
        zero_models();
        repeat (3) tick();

        // Reset state.
        check("rst_ready", rdy[0], 1'b0);
        check("rst_busy", bsy[0], 1'b0);
        check("rst_rvalid", rvld[3], 1'b0);
        check("rst_aerr", aerr[4], 1'b0);
        check("rst_bus_up_z", rd_up, 8'hFF);
        check("rst_bus_dn_z", rd_dn, 8'h00);

        // Reset-clear with req_valid held high throughout.
        req_valid = 1'b1;
        time_clear("clear");
        oor_en = 1'b1;
        for (int a = 0; a < 16; a++) do_read(4'(a));
        idle(6);

        // Latency sweep.
        do_write(4'd3, 8'hA5);
        do_read(4'd3);
        idle(6);

        // Back-to-back reads, including read right after write.
        do_write(4'd0, 8'h11);
        do_write(4'd1, 8'h22);
        do_write(4'd2, 8'h33);
        do_read(4'd2);
        do_read(4'd1);
        do_read(4'd0);
        do_write(4'd7, 8'h4E);
        do_read(4'd7);
        do_read(4'd7);
        do_write(4'd7, 8'h99);
        idle(6);

        // Out-of-range on the depth-12 instance.
        do_write(4'd13, 8'hFF);
        do_read(4'd13);
        do_read(4'd1);
        do_write(4'd11, 8'h6B);
        do_read(4'd11);
        do_read(4'd12);
        idle(6);

        // Reset while reads are in flight, then reset again mid-clear.
        do_read(4'd2);
        rst = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            due_q[i].delete();
        end
        tick();
        check("flush_rvalid", rvld[3], 1'b0);
        rst = 1'b0;
        repeat (5) tick();
        check("midclear_busy", bsy[0], 1'b1);
        rst = 1'b1;
        tick();
        time_clear("restart");
        do_read(4'd3);
        do_read(4'd13);
        do_read(4'd2);
        idle(6);

        // Tri-state bus and held value.
        do_write(4'd5, 8'h5C);
        do_read(4'd5);
        idle(6);
        output_enable = 1'b0;
        tick();
        check("oe_off_up_z", rd_up, 8'hFF);
        check("oe_off_dn_z", rd_dn, 8'h00);
        output_enable = 1'b1;
        tick();
        check("oe_on_up_hold", rd_up, 8'h5C);
        check("oe_on_dn_hold", rd_dn, 8'h5C);
        check("oe_on_no_rvalid", rvld[0], 1'b0);
        idle(2);

        for (int i = 0; i < N; i++) begin
            check($sformatf("queue_drained_u%0d", i), exp_q[i].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
